// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - round-robin bus arbiter with registered one-hot grant and AND-OR data mux
// Optional ownership timeout and preempt pulse under BUS_ARB_TIMEOUT_EN.
module bus_arbiter_mux #(
    parameter int D_WIDTH   = 32,
    parameter int N_MASTERS = 8,
    parameter int MAX_HOLD  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_MASTERS-1:0]         req_i,
    input  logic [N_MASTERS*D_WIDTH-1:0] in_data_i,
    output logic [N_MASTERS-1:0]         grant_o,
    output logic [D_WIDTH-1:0]           out_o,
    output logic                         busy_o
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    output logic                         preempt_o
`endif
);

    localparam int PW = $clog2(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 16) begin : g_bad_masters
        $error("bus_arbiter_mux: N_MASTERS must be in 2..16");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("bus_arbiter_mux: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {S_IDLE, S_OWN} state_e;

    state_e                 state_q;
    logic [N_MASTERS-1:0]   grant_q;
    logic [PW-1:0]          ptr_q;
    logic                   busy_q;

    logic [N_MASTERS-1:0]   cand;
    logic                   owner_req;
    logic                   expired;
    logic                   win_found;
    logic [PW-1:0]          win_idx;
    logic [N_MASTERS-1:0]   win_oh;
    int                     idx;

    // The current owner is never a candidate: it either released or is being timed out.
    assign cand      = req_i & ~grant_q;
    assign owner_req = |(req_i & grant_q);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        idx       = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(ptr_q) + k) % N_MASTERS;
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
        if (win_found) begin
            win_oh[win_idx] = 1'b1;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       preempt_q;

    assign expired   = (hold_q == 8'(MAX_HOLD - 1));
    assign preempt_o = preempt_q;
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= PW'(N_MASTERS - 1);
`ifdef BUS_ARB_TIMEOUT_EN
            hold_q    <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            preempt_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        state_q <= S_OWN;
                        grant_q <= win_oh;
                        busy_q  <= 1'b1;
                        ptr_q   <= win_idx;
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                S_OWN: begin
                    if (owner_req && !expired) begin
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_q <= hold_q + 8'd1;
`endif
                    end else if (win_found) begin
                        grant_q <= win_oh;
                        ptr_q   <= win_idx;
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_q    <= '0;
                        preempt_q <= owner_req;
`endif
                    end else if (owner_req) begin
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_q <= '0;
`endif
                    end else begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_o = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            out_o = out_o | ({D_WIDTH{grant_q[i]}} & in_data_i[i*D_WIDTH +: D_WIDTH]);
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb/tb_bus_arbiter_mux.sv - table-driven bench for bus_arbiter_mux (timeout cases under BUS_ARB_TIMEOUT_EN)
module tb_bus_arbiter_mux;

    localparam int DW = 32;
    localparam int NM = 8;

    logic             clk;
    logic             rst;
    logic [NM-1:0]    req;
    logic [NM*DW-1:0] in_data;
    logic [NM-1:0]    grant;
    logic [DW-1:0]    bus_out;
    logic             busy;
`ifdef BUS_ARB_TIMEOUT_EN
    logic             preempt;
`endif

    int tests = 0;
    int fails = 0;
    logic mon_en = 1'b0;

    bus_arbiter_mux #(.D_WIDTH(DW), .N_MASTERS(NM), .MAX_HOLD(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .in_data_i (in_data),
        .grant_o   (grant),
        .out_o     (bus_out),
        .busy_o    (busy)
`ifdef BUS_ARB_TIMEOUT_EN
        ,
        .preempt_o (preempt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] req;
        logic [7:0] exp_grant;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] master_word(input int i);
        return (i == 0) ? 32'hDEADBEEF : 32'h1111_1111 * i;
    endfunction

    function automatic logic [31:0] exp_out(input logic [7:0] g);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NM; i++) begin
            if (g[i]) r = r | master_word(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic r, input logic [7:0] q, input logic [7:0] g);
        vec_t v;
        v.name = n; v.rst = r; v.req = q; v.exp_grant = g;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if (!$onehot0(grant)) begin
                fails++;
                $display("FAIL onehot: got grant %h expected at most one bit set", grant);
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NM; i++) in_data[i*DW +: DW] = master_word(i);

        add("reset", 1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) add("idle", 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) add("hold0", 1'b0, 8'h01, 8'h01);
        add("release0", 1'b0, 8'h00, 8'h00);
        add("reset_rot", 1'b1, 8'h00, 8'h00);
        for (int k = 0; k <= 8; k++) begin
            logic [7:0] q;
            q = (k == 0) ? 8'hFF : ~(8'h01 << (k - 1));
            add("rotate", 1'b0, q, 8'h01 << (k % 8));
        end
        add("reset_rr", 1'b1, 8'h00, 8'h00);
        add("own3", 1'b0, 8'h08, 8'h08);
        add("own3_hold", 1'b0, 8'h28, 8'h08);
        add("drop3_pick5", 1'b0, 8'h22, 8'h20);
        add("own5_hold", 1'b0, 8'h22, 8'h20);
        add("drop5_pick1", 1'b0, 8'h02, 8'h02);
        add("idle_rr", 1'b0, 8'h00, 8'h00);
        add("reset_mid", 1'b1, 8'h00, 8'h00);
        add("own2", 1'b0, 8'h04, 8'h04);
        add("own2_hold", 1'b0, 8'h04, 8'h04);
        add("rst_mid_xfer", 1'b1, 8'h04, 8'h00);
        add("after_rst", 1'b0, 8'h0C, 8'h04);
        add("drop2_pick3", 1'b0, 8'h08, 8'h08);
        add("idle_end", 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            tick();
            mon_en = 1'b1;
            check({vecs[i].name, ".grant"}, 32'(grant), 32'(vecs[i].exp_grant));
            check({vecs[i].name, ".busy"}, 32'(busy), 32'(|vecs[i].exp_grant));
            check({vecs[i].name, ".out"}, bus_out, exp_out(vecs[i].exp_grant));
        end
        rst = 1'b0;

        do_reset();
        req = 8'h01;
        tick();
        check("track.out0", bus_out, 32'hDEADBEEF);
        in_data[0 +: DW] = 32'hCAFEF00D;
        #1;
        check("track.owner_change", bus_out, 32'hCAFEF00D);
        in_data[DW +: DW] = 32'h5A5A5A5A;
        #1;
        check("track.other_change", bus_out, 32'hCAFEF00D);
        in_data[0 +: DW]  = master_word(0);
        in_data[DW +: DW] = master_word(1);
        req = 8'h00;
        tick();
        check("track.idle_out", bus_out, 32'h0);

`ifdef BUS_ARB_TIMEOUT_EN
        do_reset();
        req = 8'h03;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("timeout.grant", 32'(grant), ((c / 4) % 2 == 0) ? 32'h01 : 32'h02);
            check("timeout.preempt", 32'(preempt), (c > 0 && c % 4 == 0) ? 32'h1 : 32'h0);
        end
        do_reset();
        req = 8'h01;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("regrant.grant", 32'(grant), 32'h01);
            check("regrant.preempt", 32'(preempt), 32'h0);
        end
        req = 8'h00;
        tick();
`endif

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
